// File: rtl/mram_din_burst_arbiter.sv
// Round-robin burst arbiter in front of the MRAM write-data FIFO: one requester owns the write port for a whole burst.
// Latency: grant 1 cycle after request in IDLE; beat valid/data/ready are combinational while a burst is active.
// Backpressure: fifo_ready_i low stalls the burst (state, count and data hold); a missing beat valid waits indefinitely.
module mram_din_burst_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_valid_o,
  input  logic                          fifo_ready_i,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                 r_state;
  logic [SEL_W-1:0]       r_sel;
  logic [SEL_W-1:0]       r_ptr;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic [NUM_REQ-1:0]     r_gnt;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_any;
  logic [SEL_W-1:0]       w_win;
  int                     w_scan;
  logic [SEL_W-1:0]       w_scan_idx;
  logic [LEN_WIDTH-1:0]   w_win_len;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic                   w_sel_valid;
  logic                   w_beat;

  // Round-robin pick: first requesting index scanning upward from the slot after the last one served.
  always_comb begin
    w_any      = 1'b0;
    w_win      = '0;
    w_scan     = 0;
    w_scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan = int'(r_ptr) + 1 + i;
      if (w_scan >= NUM_REQ) begin
        w_scan = w_scan - NUM_REQ;
      end
      w_scan_idx = SEL_W'(w_scan);
      if (!w_any && req_i[w_scan_idx]) begin
        w_any = 1'b1;
        w_win = w_scan_idx;
      end
    end
  end

  // Slice muxes: burst length of the arbitration winner, data/valid of the current owner.
  always_comb begin
    w_win_len   = '0;
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (SEL_W'(k) == w_win) begin
        w_win_len = req_len_i[k*LEN_WIDTH +: LEN_WIDTH];
      end
      if (SEL_W'(k) == r_sel) begin
        w_sel_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_valid = req_valid_i[k];
      end
    end
  end

  // Write-port mux: only the owner reaches the FIFO, everything is quiet outside a burst.
  always_comb begin
    fifo_valid_o = 1'b0;
    fifo_data_o  = '0;
    req_ready_o  = '0;
    if (r_state == S_BURST) begin
      fifo_valid_o = w_sel_valid;
      fifo_data_o  = w_sel_data;
      req_ready_o  = r_gnt & {NUM_REQ{fifo_ready_i}};
    end
  end

  assign w_beat = fifo_valid_o & fifo_ready_i;

  // Burst FSM: grant in IDLE, count beats down in BURST, release and pulse done after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_ptr   <= SEL_W'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_BURST;
            r_sel   <= w_win;
            r_cnt   <= w_win_len;
            r_gnt   <= NUM_REQ'(1) << w_win;
            r_busy  <= 1'b1;
          end
        end
        S_BURST: begin
          if (w_beat) begin
            if (r_cnt == '0) begin
              r_state <= S_IDLE;
              r_gnt   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_ptr   <= r_sel;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o  = r_gnt;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_mram_din_burst_arbiter.sv
// Bench for mram_din_burst_arbiter: directed bursts, expected beats queued at issue time, a negedge monitor pops and compares.
module tb_mram_din_burst_arbiter;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_i;
  logic [N*LW-1:0]   req_len_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [N-1:0]      gnt_o;
  logic [DW-1:0]     fifo_data_o;
  logic              fifo_valid_o;
  logic              fifo_ready_i;
  logic              busy_o;
  logic              done_o;

  mram_din_burst_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .req_len_i    (req_len_i),
    .req_data_i   (req_data_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .gnt_o        (gnt_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_valid_o (fifo_valid_o),
    .fifo_ready_i (fifo_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [9:0] d;
    bit         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_beats  = 0;
  int   exp_beat[N];
  int   beat_idx[N];
  bit   prev_last = 1'b0;

  function automatic logic [9:0] dval(input int k, input int b);
    return 10'((k << 7) | (b & 127));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Requester model: each requester presents its next beat, advancing when the beat is accepted.
  always_comb begin
    req_data_i = '0;
    for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = dval(k, beat_idx[k]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++)
      if (req_ready_o[k] && req_valid_i[k]) beat_idx[k] <= beat_idx[k] + 1;
  end

  // Monitor: compare every accepted beat with the queue head, and the done pulse after each last beat.
  always @(negedge clk) begin
    exp_t e;
    if (prev_last) begin
      chk("done_pulse", 32'(done_o), 32'd1);
      chk("gnt_clear_at_done", 32'(gnt_o), 32'd0);
    end else if (done_o) begin
      chk("spurious_done", 32'(done_o), 32'd0);
    end
    prev_last = 1'b0;
    if (fifo_valid_o && fifo_ready_i) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(fifo_data_o), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(fifo_data_o), 32'(e.d));
        chk("beat_gnt", 32'(gnt_o), 32'(1 << e.k));
        chk("beat_ready", 32'(req_ready_o), 32'(1 << e.k));
        prev_last = e.last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int k, input int l);
    req_len_i[k*LW +: LW] = LW'(l);
  endtask

  task automatic push_burst(input int k, input int nb, input bit mark_last);
    exp_t e;
    for (int m = 0; m < nb; m++) begin
      e.k    = k;
      e.d    = dval(k, exp_beat[k] + m);
      e.last = mark_last && (m == nb - 1);
      exp_q.push_back(e);
    end
    exp_beat[k] += nb;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_done"},  32'(done_o), 32'd0);
    chk({tag, "_valid"}, 32'(fifo_valid_o), 32'd0);
    chk({tag, "_data"},  32'(fifo_data_o), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd0);
  endtask

  task automatic do_reset(input bit check);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    #1;
    if (check) check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int b0;
    int base;
    int nb;
    int pat[7];
    pat = '{1, 0, 0, 1, 1, 0, 1};
    for (int k = 0; k < N; k++) begin
      exp_beat[k] = 0;
      beat_idx[k] = 0;
    end
    req_i        = '0;
    req_len_i    = '0;
    req_valid_i  = '1;
    fifo_ready_i = 1'b1;
    do_reset(1'b1);

    // 1: single requester, len=2
    set_len(0, 2);
    push_burst(0, 3, 1'b1);
    b0 = n_beats;
    req_i = 4'b0001;
    #1;
    chk("t1_gnt_before_edge", 32'(gnt_o), 32'd0);
    tick();
    chk("t1_gnt_latency", 32'(gnt_o), 32'b0001);
    chk("t1_busy", 32'(busy_o), 32'd1);
    req_i = '0;
    repeat (5) tick();
    chk("t1_beats", 32'(n_beats - b0), 32'd3);

    // 2: all requesting, len=0, round-robin 0,1,2,3,0 at one beat per 2 cycles
    do_reset(1'b0);
    for (int k = 0; k < N; k++) set_len(k, 0);
    for (int k = 0; k < 5; k++) push_burst(k % N, 1, 1'b1);
    b0 = n_beats;
    req_i = 4'b1111;
    repeat (10) tick();
    req_i = '0;
    chk("t2_throughput", 32'(n_beats - b0), 32'd5);
    repeat (2) tick();
    chk("t2_idle_after", 32'(busy_o), 32'd0);

    // 3: backpressure pattern on a len=3 burst
    do_reset(1'b0);
    set_len(0, 3);
    base = exp_beat[0];
    push_burst(0, 4, 1'b1);
    b0 = n_beats;
    req_i = 4'b0001;
    tick();
    req_i = '0;
    chk("t3_gnt", 32'(gnt_o), 32'b0001);
    nb = 0;
    for (int p = 0; p < 7; p++) begin
      fifo_ready_i = pat[p][0];
      #1;
      if (pat[p] == 0) begin
        chk("t3_stall_data", 32'(fifo_data_o), 32'(dval(0, base + nb)));
        chk("t3_stall_ready", 32'(req_ready_o), 32'd0);
      end
      @(posedge clk);
      nb += pat[p];
      #1;
    end
    fifo_ready_i = 1'b1;
    tick();
    chk("t3_beats", 32'(n_beats - b0), 32'd4);

    // 4: request dropped after beat 1, valid gap of 3 cycles
    do_reset(1'b0);
    set_len(2, 4);
    push_burst(2, 5, 1'b1);
    b0 = n_beats;
    req_i = 4'b0100;
    tick();
    chk("t4_gnt", 32'(gnt_o), 32'b0100);
    tick();
    req_i = '0;
    req_valid_i = 4'b1011;
    repeat (3) begin
      #1;
      chk("t4_gap_valid", 32'(fifo_valid_o), 32'd0);
      chk("t4_gap_ready", 32'(req_ready_o), 32'b0100);
      chk("t4_gap_busy", 32'(busy_o), 32'd1);
      @(posedge clk);
      #1;
    end
    req_valid_i = '1;
    repeat (5) tick();
    chk("t4_beats", 32'(n_beats - b0), 32'd5);

    // 5: reset after beat 2 of a len=5 burst, then requester 1 wins first again
    do_reset(1'b0);
    set_len(1, 5);
    push_burst(1, 2, 1'b0);
    req_i = 4'b0010;
    tick();
    chk("t5_gnt", 32'(gnt_o), 32'b0010);
    req_i = '0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check_all_zero("t5_midreset");
    req_i = 4'b1010;
    set_len(1, 0);
    set_len(3, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_burst(1, 1, 1'b1);
    tick();
    chk("t5_gnt_after_reset", 32'(gnt_o), 32'b0010);
    req_i = '0;
    repeat (3) tick();

    // 6: maximum length, 256 beats
    do_reset(1'b0);
    set_len(0, 255);
    push_burst(0, 256, 1'b1);
    b0 = n_beats;
    req_i = 4'b0001;
    tick();
    req_i = '0;
    for (int c = 0; c < 400 && (n_beats - b0) < 256; c++) tick();
    chk("t6_beats", 32'(n_beats - b0), 32'd256);
    repeat (3) tick();
    chk("t6_no_extra_beats", 32'(n_beats - b0), 32'd256);
    chk("t6_idle_busy", 32'(busy_o), 32'd0);
    chk("t6_idle_gnt", 32'(gnt_o), 32'd0);
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
